// File: rtl/dmem_ctrl.sv
// Data-memory controller: two-port round-robin arbiter feeding four byte-lane banks,
// with misaligned byte/half/word access and a registered, sign/zero-extended load response.
module dmem_ctrl #(
   parameter int AW = 9,
   parameter int DW = 8,
   parameter int NP = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NP-1:0]        req_i,
   input  logic [NP-1:0]        we_i,
   input  logic [NP*(AW+2)-1:0] addr_i,
   input  logic [NP*2-1:0]      size_i,
   input  logic [NP-1:0]        uns_i,
   input  logic [NP*32-1:0]     wdata_i,
   output logic [NP-1:0]        gnt_o,
   output logic [NP-1:0]        rvalid_o,
   output logic [NP*32-1:0]     rdata_o,
   output logic [NP-1:0]        err_o,
   output logic [4*AW-1:0]      bank_addr_o,
   output logic [3:0]           bank_wr_o,
   output logic [4*DW-1:0]      bank_wdata_o,
   input  logic [4*DW-1:0]      bank_rdata_i
);
   localparam int BW = AW + 2;

   logic [BW-1:0] p_addr  [NP];
   logic [1:0]    p_size  [NP];
   logic [31:0]   p_wdata [NP];

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_port
         assign p_addr[gi]  = addr_i[gi*BW +: BW];
         assign p_size[gi]  = size_i[gi*2 +: 2];
         assign p_wdata[gi] = wdata_i[gi*32 +: 32];
      end
   endgenerate

   // prio_q names the port that wins the next contended cycle
   logic prio_q, prio_d;
   logic sel;

   always_comb begin
      gnt_o  = '0;
      prio_d = prio_q;
      if (!rst) begin
         if (req_i[0] && req_i[1]) gnt_o[prio_q] = 1'b1;
         else                      gnt_o = req_i;
         if (gnt_o[0])      prio_d = 1'b1;
         else if (gnt_o[1]) prio_d = 1'b0;
      end
   end

   assign sel = gnt_o[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prio_q <= 1'b0;
      else     prio_q <= prio_d;
   end

   logic          ex_valid_q;
   logic          ex_port_q;
   logic          ex_we_q;
   logic [BW-1:0] ex_addr_q;
   logic [1:0]    ex_size_q;
   logic          ex_uns_q;
   logic [31:0]   ex_wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_port_q  <= 1'b0;
         ex_we_q    <= 1'b0;
         ex_addr_q  <= '0;
         ex_size_q  <= 2'b00;
         ex_uns_q   <= 1'b0;
         ex_wdata_q <= '0;
      end else begin
         ex_valid_q <= |gnt_o;
         if (|gnt_o) begin
            ex_port_q  <= sel;
            ex_we_q    <= we_i[sel];
            ex_addr_q  <= p_addr[sel];
            ex_size_q  <= p_size[sel];
            ex_uns_q   <= uns_i[sel];
            ex_wdata_q <= p_wdata[sel];
         end
      end
   end

   logic [2:0] nbytes;
   always_comb begin
      case (ex_size_q)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         2'b10:   nbytes = 3'd4;
         default: nbytes = 3'd0;
      endcase
   end

   // raw holds the access bytes in order k, gathered from lane (base+k)%4
   logic [31:0] raw;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [1:0]    k;
         logic [1:0]    lsel;
         logic [BW-1:0] baddr;
         logic          touched;
         assign k       = 2'(gi) - ex_addr_q[1:0];
         assign baddr   = ex_addr_q + BW'(k);
         assign touched = ({1'b0, k} < nbytes);
         assign bank_addr_o[gi*AW +: AW]  = touched ? baddr[BW-1:2] : ex_addr_q[BW-1:2];
         assign bank_wr_o[gi]             = ex_valid_q && ex_we_q && touched && !rst;
         assign bank_wdata_o[gi*DW +: DW] = ex_wdata_q[32'(k)*DW +: DW];
         assign lsel = ex_addr_q[1:0] + 2'(gi);
         assign raw[gi*DW +: DW] = bank_rdata_i[32'(lsel)*DW +: DW];
      end
   endgenerate

   logic [31:0] resp_data;
   logic        resp_err;

   always_comb begin
      resp_data = '0;
      resp_err  = (ex_size_q == 2'b11);
      if (!ex_we_q) begin
         case (ex_size_q)
            2'b00:   resp_data = {{24{~ex_uns_q & raw[7]}}, raw[7:0]};
            2'b01:   resp_data = {{16{~ex_uns_q & raw[15]}}, raw[15:0]};
            2'b10:   resp_data = raw;
            default: resp_data = '0;
         endcase
      end
   end

   logic [NP-1:0]    rvalid_q;
   logic [NP-1:0]    err_q;
   logic [NP*32-1:0] rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_q <= '0;
         err_q    <= '0;
         rdata_q  <= '0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            rvalid_q[p] <= ex_valid_q && (int'(ex_port_q) == p);
            if (ex_valid_q && (int'(ex_port_q) == p)) begin
               rdata_q[p*32 +: 32] <= resp_data;
               err_q[p]            <= resp_err;
            end
         end
      end
   end

   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;
   assign rdata_o  = rdata_q;

endmodule
